paint_ctrl: RTL and testbench

Cursor and framebuffer-write controller for the drawing board. It turns debounced direction buttons into a saturating (x, y) cursor with press-and-hold auto-repeat. It issues pen writes of the selected 12-bit colour into the video RAM write port and owns a full-screen clear sequence. It sits between the board inputs and the VRAM; the VGA scan side reads the VRAM independently.

---
 rtl/paint_pkg.sv | 24 ++
 rtl/dir_repeat.sv | 68 ++++++
 rtl/paint_ctrl.sv | 121 ++++++++++++
 tb/tb_paint_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared types and constants for the paint cursor / VRAM write controller.
// The clear sweep in paint_ctrl is built only when PAINT_CLEAR_EN is defined.
package paint_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam logic [11:0] CLEAR_COLOR = 12'h000;

  // A move is active when at least one axis has a non-cancelled button.
  function automatic logic move_active(input logic [3:0] dirc);
    return (dirc[DIR_UP] ^ dirc[DIR_DOWN]) | (dirc[DIR_LEFT] ^ dirc[DIR_RIGHT]);
  endfunction

endpackage

// File: rtl/dir_repeat.sv
// Press-and-hold sequencer: one step on press, another after HOLD_CYC cycles,
// then one every REPEAT_CYC cycles while the move stays active.
module dir_repeat
  import paint_pkg::*;
#(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   active,
  input  logic   abort,
  output logic   step,
  output state_t state
);

  localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW      = $clog2(MAX_CYC);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REPEAT_LD = CW'(REPEAT_CYC - 1);

  logic [CW-1:0] cnt;

  // step is a decode of the current state so the cursor moves on the very
  // edge that samples the press or the counter expiry.
  always_comb begin
    step = 1'b0;
    if (!abort && active) begin
      case (state)
        IDLE:        step = 1'b1;
        HOLD,
        REPEAT:      step = (cnt == '0);
        default:     step = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (abort || !active) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= HOLD;
          cnt   <= HOLD_LD;
        end
        HOLD,
        REPEAT: begin
          if (cnt == '0) begin
            state <= REPEAT;
            cnt   <= REPEAT_LD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/paint_ctrl.sv
// Cursor, pen-write and full-screen clear controller for the drawing board VRAM.
// Define PAINT_CLEAR_EN to build the clear sweep; otherwise clr is ignored.
module paint_ctrl
  import paint_pkg::*;
#(
  parameter int XW         = 8,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      dirc,
  input  logic            draw,
  input  logic            clr,
  input  logic [3:0]      r,
  input  logic [3:0]      g,
  input  logic [3:0]      b,
  output logic [XW-1:0]   cur_x,
  output logic [XW-1:0]   cur_y,
  output logic            we,
  output logic [2*XW-1:0] waddr,
  output logic [11:0]     wdata,
  output logic            busy,
  output state_t          state
);

  localparam logic [XW-1:0] CENTRE = XW'(1) << (XW - 1);

  logic          active;
  logic          abort;
  logic          step;
  state_t        rep_state;
  logic [XW-1:0] nx;
  logic [XW-1:0] ny;

  assign active = move_active(dirc);

`ifdef PAINT_CLEAR_EN
  // A clr request holds the sequencer off in the same cycle it is sampled.
  assign abort = busy | clr;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign abort      = 1'b0;
  assign busy       = 1'b0;
`endif

  assign state = busy ? CLEAR : rep_state;

  dir_repeat #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_dir_repeat (
    .clk    (clk),
    .rst    (rst),
    .active (active),
    .abort  (abort),
    .step   (step),
    .state  (rep_state)
  );

  // Saturating per-axis step; a blocked axis does not stop the other one.
  always_comb begin
    nx = cur_x;
    ny = cur_y;
    if (step) begin
      if (dirc[DIR_RIGHT] && !dirc[DIR_LEFT] && cur_x != '1) nx = cur_x + XW'(1);
      if (dirc[DIR_LEFT] && !dirc[DIR_RIGHT] && cur_x != '0) nx = cur_x - XW'(1);
      if (dirc[DIR_DOWN] && !dirc[DIR_UP] && cur_y != '1)    ny = cur_y + XW'(1);
      if (dirc[DIR_UP] && !dirc[DIR_DOWN] && cur_y != '0)    ny = cur_y - XW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x <= CENTRE;
      cur_y <= CENTRE;
    end else begin
      cur_x <= nx;
      cur_y <= ny;
    end
  end

  // Address and data only load on a pen write, so they keep the last
  // written pixel while we is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
`ifdef PAINT_CLEAR_EN
      busy  <= 1'b0;
`endif
    end else
`ifdef PAINT_CLEAR_EN
    if (busy) begin
      wdata <= CLEAR_COLOR;
      if (waddr == '1) begin
        busy <= 1'b0;
        we   <= 1'b0;
      end else begin
        we    <= 1'b1;
        waddr <= waddr + (2*XW)'(1);
      end
    end else if (clr) begin
      busy  <= 1'b1;
      we    <= 1'b1;
      waddr <= '0;
      wdata <= CLEAR_COLOR;
    end else
`endif
    begin
      we <= draw;
      if (draw) begin
        waddr <= {cur_y, cur_x};
        wdata <= {r, g, b};
      end
    end
  end

endmodule

// File: tb/tb_paint_ctrl.sv
// Self-checking bench for paint_ctrl: directed table, corner sequences, and
// randomized traffic against a cycle-count reference model.
module tb_paint_ctrl;
  import paint_pkg::*;

  localparam int XW   = 4;
  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int NPIX = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dirc;
  logic        draw;
  logic        clr;
  logic [3:0]  r, g, b;
  logic [3:0]  cur_x, cur_y;
  logic        we;
  logic [7:0]  waddr;
  logic [11:0] wdata;
  logic        busy;
  state_t      state;

  paint_ctrl #(.XW(XW), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut (
    .clk(clk), .rst(rst), .dirc(dirc), .draw(draw), .clr(clr),
    .r(r), .g(g), .b(b), .cur_x(cur_x), .cur_y(cur_y),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: cursor, write port, and how long the move has been held.
  int          m_x, m_y;
  logic        m_we;
  logic [7:0]  m_waddr;
  logic [11:0] m_wdata;
  logic        m_busy;
  int          age  = -1;
  int          cidx = -1;

  typedef struct packed {
    logic [3:0]  dirc;
    logic        draw;
    logic [11:0] rgb;
    logic [3:0]  ex;
    logic [3:0]  ey;
    logic        ewe;
    logic [7:0]  ewaddr;
    logic [11:0] ewdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] d, input logic dr, input logic [11:0] c,
                              input logic [3:0] ex, input logic [3:0] ey, input logic ew,
                              input logic [7:0] ea, input logic [11:0] ed);
    vec_t v;
    v = '{d, dr, c, ex, ey, ew, ea, ed};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int dx, dy;
    if (rst) begin
      m_x = 8; m_y = 8; m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
      age = -1; cidx = -1;
      return;
    end
`ifdef PAINT_CLEAR_EN
    if (cidx >= 0) begin
      age = -1;
      if (cidx == NPIX - 1) begin
        cidx = -1; m_busy = 0; m_we = 0;
      end else begin
        cidx++;
        m_waddr = 8'(cidx);
      end
      return;
    end
    if (clr) begin
      cidx = 0; m_busy = 1; m_we = 1; m_waddr = 0; m_wdata = 0; age = -1;
      return;
    end
`endif
    m_we = draw;
    if (draw) begin
      m_waddr = 8'(m_y * 16 + m_x);
      m_wdata = {r, g, b};
    end
    dx = (dirc[DIR_RIGHT] ? 1 : 0) - (dirc[DIR_LEFT] ? 1 : 0);
    dy = (dirc[DIR_DOWN] ? 1 : 0) - (dirc[DIR_UP] ? 1 : 0);
    if (dx != 0 || dy != 0) begin
      age = (age < 0) ? 0 : age + 1;
      if (age == 0 || (age >= HOLD && (age - HOLD) % REP == 0)) begin
        if (m_x + dx >= 0 && m_x + dx <= 15) m_x = m_x + dx;
        if (m_y + dy >= 0 && m_y + dy <= 15) m_y = m_y + dy;
      end
    end else begin
      age = -1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_cur_x", cur_x, m_x);
    check("model_cur_y", cur_y, m_y);
    check("model_we", we, m_we);
    check("model_busy", busy, m_busy);
    if (m_we) begin
      check("model_waddr", waddr, m_waddr);
      check("model_wdata", wdata, m_wdata);
    end
  endtask

  task automatic tap(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      dirc = d; cycle();
      dirc = 4'h0; cycle();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; dirc = 0; draw = 0; clr = 0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic check_cur(input string name, input int x, input int y);
    check({name, "_x"}, cur_x, x);
    check({name, "_y"}, cur_y, y);
  endtask

  initial begin
    rst = 1'b1; dirc = 0; draw = 0; clr = 0; r = 0; g = 0; b = 0;
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_state", 32'(state), 32'(IDLE));
    check_cur("reset_cur", 8, 8);
    check("reset_busy", busy, 0);

    // Directed vectors starting from the centre.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(4'h0, 0, 12'h000, 8, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 9, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 9, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 9, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 9, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 10, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 10, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 11, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 11, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 12, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 12, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h8, 0, 12'h000, 13, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h0, 0, 12'h000, 13, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h0, 0, 12'h000, 13, 8, 0, 8'h00, 12'h000));
    tbl.push_back(mk(4'h0, 1, 12'hF0A, 13, 8, 1, 8'h8D, 12'hF0A));
    tbl.push_back(mk(4'h0, 1, 12'hF0A, 13, 8, 1, 8'h8D, 12'hF0A));
    tbl.push_back(mk(4'h0, 0, 12'h123, 13, 8, 0, 8'h8D, 12'hF0A));
    // Diagonal right+down into the right edge: x saturates, y keeps moving.
    tbl.push_back(mk(4'hA, 0, 12'h000, 14, 9, 0, 8'h8D, 12'hF0A));
    tbl.push_back(mk(4'hA, 0, 12'h000, 14, 9, 0, 8'h8D, 12'hF0A));
    tbl.push_back(mk(4'hA, 0, 12'h000, 14, 9, 0, 8'h8D, 12'hF0A));
    tbl.push_back(mk(4'hA, 0, 12'h000, 14, 9, 0, 8'h8D, 12'hF0A));
    tbl.push_back(mk(4'hA, 0, 12'h000, 15, 10, 0, 8'h8D, 12'hF0A));
    tbl.push_back(mk(4'hA, 0, 12'h000, 15, 10, 0, 8'h8D, 12'hF0A));
    tbl.push_back(mk(4'hA, 0, 12'h000, 15, 11, 0, 8'h8D, 12'hF0A));
    tbl.push_back(mk(4'h0, 0, 12'h000, 15, 11, 0, 8'h8D, 12'hF0A));

    for (int i = 0; i < tbl.size(); i++) begin
      dirc = tbl[i].dirc;
      draw = tbl[i].draw;
      {r, g, b} = tbl[i].rgb;
      cycle();
      check($sformatf("tbl%0d_x", i), cur_x, tbl[i].ex);
      check($sformatf("tbl%0d_y", i), cur_y, tbl[i].ey);
      check($sformatf("tbl%0d_we", i), we, tbl[i].ewe);
      check($sformatf("tbl%0d_waddr", i), waddr, tbl[i].ewaddr);
      check($sformatf("tbl%0d_wdata", i), wdata, tbl[i].ewdata);
    end

    // Pen write at (5,6).
    do_reset();
    tap(4'h4, 3);
    tap(4'h1, 2);
    check_cur("pos56", 5, 6);
    draw = 1; {r, g, b} = 12'hF0A;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("pen_we", we, 1);
      check("pen_waddr", waddr, 8'h65);
      check("pen_wdata", wdata, 12'hF0A);
    end
    draw = 0;
    cycle();
    check("pen_off_we", we, 0);

    // Diagonal against the left edge, then opposing buttons cancelling.
    tap(4'h4, 6);
    tap(4'h1, 3);
    check_cur("pos03", 0, 3);
    dirc = 4'h5; cycle();
    check_cur("upleft", 0, 2);
    dirc = 4'h0; cycle();
    tap(4'h2, 1);
    check_cur("back03", 0, 3);
    dirc = 4'h3;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_cur("cancel", 0, 3);
    end
    dirc = 4'h0; cycle();

`ifdef PAINT_CLEAR_EN
    begin
      int busy_cnt;
      busy_cnt = 0;
      dirc = 4'h8; draw = 1; clr = 1; {r, g, b} = 12'hABC;
      cycle();
      clr = 0;
      if (busy) busy_cnt++;
      check("clr_busy0", busy, 1);
      check("clr_we0", we, 1);
      check("clr_waddr0", waddr, 0);
      check("clr_wdata0", wdata, 0);
      check("clr_state", 32'(state), 32'(CLEAR));
      check_cur("clr_cur0", 0, 3);
      for (int i = 1; i < NPIX; i++) begin
        dirc = (i >= NPIX - 4) ? 4'h0 : 4'($urandom_range(0, 15));
        cycle();
        if (busy) busy_cnt++;
        check("clr_waddr", waddr, i);
        check("clr_we", we, 1);
        check("clr_wdata", wdata, 0);
        check_cur("clr_cur", 0, 3);
      end
      cycle();
      check("clr_done_busy", busy, 0);
      check("clr_busy_cycles", busy_cnt, NPIX);
      check_cur("clr_done_cur", 0, 3);
      draw = 0;
      cycle();

      clr = 1; cycle(); clr = 0;
      for (int i = 0; i < 100; i++) cycle();
      check("abort_addr", waddr, 100);
      rst = 1; cycle(); rst = 0;
      check("abort_busy", busy, 0);
      check("abort_we", we, 0);
      check("abort_waddr", waddr, 0);
      check_cur("abort_cur", 8, 8);
    end
`else
    draw = 0; clr = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("noclr_busy", busy, 0);
    end
    clr = 0;
`endif

    // Randomized traffic; dirc is sticky so holds and repeats occur.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) dirc = 4'($urandom_range(0, 15));
      draw = 1'($urandom_range(0, 1));
      {r, g, b} = 12'($urandom_range(0, 4095));
      clr  = ($urandom_range(0, 299) == 0);
      rst  = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 0; clr = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
